// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {HI=remainder, LO=quotient} and the pipeline freeze request div_stall.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  input  logic               hold,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               div_stall
);

  // state | meaning
  // IDLE  | waiting for an accepted start
  // BUSY  | one quotient bit per cycle, MSB first, WIDTH cycles
  // DONE  | result valid for the instruction in E; held while hold=1
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic             q_neg, r_neg, div0;
  logic             accept, finish;

  logic [WIDTH:0]   rem_shift;
  logic             take;
  logic [WIDTH-1:0] rem_step, q_step, q_fix, r_fix, a_abs, b_abs;

  // dvd doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    take      = rem_shift >= {1'b0, dvs};
    rem_step  = take ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
    q_step    = {dvd[WIDTH-2:0], take};
    q_fix     = div0 ? '1 : (q_neg ? -q_step : q_step);
    r_fix     = r_neg ? -rem_step : rem_step;
    a_abs     = (signed_div && a[WIDTH-1]) ? -a : a;
    b_abs     = (signed_div && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    div_stall = 1'b0;
    ready     = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          accept    = 1'b1;
          div_stall = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        div_stall = 1'b1;
        if (annul) begin
          state_d = IDLE;
        end else if (cnt == CW'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          ready = 1'b1;
          if (!hold) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Divide-by-zero falls out of the loop with rem=|a|, so only LO needs forcing.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      div0   <= 1'b0;
      result <= '0;
    end else if (accept) begin
      dvd    <= a_abs;
      dvs    <= b_abs;
      rem    <= '0;
      cnt    <= '0;
      q_neg  <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg  <= signed_div & a[WIDTH-1];
      div0   <= (b == '0);
    end else if (state == BUSY && !annul) begin
      dvd <= q_step;
      rem <= rem_step;
      cnt <= cnt + CW'(1);
      if (finish) result <= {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: vector table, scoreboard and corner sequences.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul, hold;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, div_stall;

  div_radix2 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .hold(hold),
    .result(result), .ready(ready), .div_stall(div_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t        tbl[12];
  logic [63:0] sb[$];
  logic [63:0] last_res;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        ready_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit s);
    int xs, ys, qs, rs;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (!s) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    xs = x; ys = y; qs = xs / ys; rs = xs % ys;
    return {rs, qs};
  endfunction

  // Scoreboard: each rising edge of ready consumes one expected result.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ready: got result %h with no operation expected", result);
      end else begin
        chk("sb_result", result, sb.pop_front());
      end
    end
    ready_prev = ready;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle ready is first seen; operands are scrambled while waiting.
  task automatic wait_ready(output int n, output bit got, output bit stall_ok);
    n = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && n < 40) begin
      next_cycle();
      a = $urandom; b = $urandom;
      #1;
      n++;
      if (ready) got = 1'b1;
      else if (!div_stall) stall_ok = 1'b0;
    end
  endtask

  task automatic wait_checks(input string tag, input int exp_n);
    int n; bit got, sok;
    wait_ready(n, got, sok);
    chk({tag, "_ready_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    chk({tag, "_stall_busy"}, 64'(sok), 64'd1);
    chk({tag, "_stall_done"}, 64'(div_stall), 64'd0);
  endtask

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit s, input logic [63:0] exp);
    start = 1'b1; a = x; b = y; signed_div = s;
    sb.push_back(exp);
    last_res = exp;
    #1;
    chk("stall_c0", 64'(div_stall), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input bit s, input logic [63:0] exp);
    next_cycle();
    launch(x, y, s, exp);
    wait_checks(tag, 33);
    next_cycle();
    start = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [31:0] x, y;
    bit s;

    tbl[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    tbl[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    tbl[4]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
    tbl[5]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};
    tbl[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    tbl[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0};
    tbl[8]  = '{32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 32'd2,          32'hFFFF_FFFE};
    tbl[9]  = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3};
    tbl[10] = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0};
    tbl[11] = '{32'h8000_0000,  32'd2,          1'b0, 32'h4000_0000,  32'd0};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; hold = 1'b0;
    a = '0; b = '0; last_res = '0;
    next_cycle(); next_cycle();
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_stall", 64'(div_stall), 64'd0);
    next_cycle();
    rst = 1'b0;
    #1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].hi, tbl[i].lo});

    // Back-to-back: start stays high, second op accepted the cycle after DONE.
    next_cycle();
    launch(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    wait_checks("b2b_first", 33);
    a = 32'd9; b = 32'd3;
    next_cycle();
    launch(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});
    wait_checks("b2b_second", 33);
    next_cycle();
    start = 1'b0;
    #1;

    // Hold across DONE with start still asserted: no restart, result stable.
    next_cycle();
    launch(32'd1234, 32'd10, 1'b0, {32'd4, 32'd123});
    wait_checks("hold", 33);
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      if (k == 3) hold = 1'b0;
      #1;
      chk("hold_ready", 64'(ready), 64'd1);
      chk("hold_result", result, {32'd4, 32'd123});
      chk("hold_stall", 64'(div_stall), 64'd0);
    end
    next_cycle();
    start = 1'b0;
    #1;
    chk("hold_idle_ready", 64'(ready), 64'd0);
    chk("hold_idle_stall", 64'(div_stall), 64'd0);

    // Annul in cycle 10 of BUSY.
    next_cycle();
    start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
    for (int c = 1; c <= 10; c++) next_cycle();
    annul = 1'b1;
    #1;
    chk("annul_stall_c10", 64'(div_stall), 64'd1);
    next_cycle();
    annul = 1'b0; start = 1'b0;
    #1;
    chk("annul_stall_c11", 64'(div_stall), 64'd0);
    chk("annul_ready_c11", 64'(ready), 64'd0);
    chk("annul_result_c11", result, last_res);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      next_cycle(); #1;
      if (ready || div_stall) seen = 1'b1;
    end
    chk("annul_quiet", 64'(seen), 64'd0);
    chk("annul_result_kept", result, last_res);

    // annul together with start in IDLE must not launch.
    next_cycle();
    start = 1'b1; annul = 1'b1;
    #1;
    chk("annul_start_stall", 64'(div_stall), 64'd0);
    next_cycle();
    start = 1'b0; annul = 1'b0;
    #1;
    chk("annul_start_idle", 64'(div_stall), 64'd0);

    // Reset in cycle 10 of BUSY.
    next_cycle();
    start = 1'b1; a = 32'd77; b = 32'd5; signed_div = 1'b0;
    for (int c = 1; c <= 10; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rstmid_stall", 64'(div_stall), 64'd0);
    chk("rstmid_ready", 64'(ready), 64'd0);
    chk("rstmid_result", result, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      next_cycle(); #1;
      if (ready) seen = 1'b1;
    end
    chk("rstmid_no_ready", 64'(seen), 64'd0);

    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i % 2 == 1) ? 32'($urandom_range(1, 100)) : 32'($urandom);
      s = (i % 3 != 0);
      run_op($sformatf("rnd%0d", i), x, y, s, model(x, y, s));
    end

    repeat (3) next_cycle();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
